// File: rtl/parity_tx.sv
// Serial frame transmitter: start, DATA_W data bits LSB-first, parity, stop.
// Optional frame counter output enabled by defining PARITY_TX_FRAME_CNT_EN.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, shift_q[0] on the line
// PARITY | latched parity bit
// STOP   | stop bit (1)
module parity_tx #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
`ifdef PARITY_TX_FRAME_CNT_EN
   ,
   output logic [7:0]        frame_cnt
`endif
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic          ODD_BIT  = (ODD_PARITY != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              par_q, par_d;
   logic              tx_d;
   logic              done_d;
   logic              bit_end;
   logic              accept;

   assign ready_out = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign accept    = valid_in & ready_out;
   assign bit_end   = (cyc_q == LAST_CYC);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      par_d   = par_q;
      done_d  = 1'b0;

      if (state_q != IDLE)
         cyc_d = bit_end ? '0 : cyc_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = data_in;
               par_d   = (^data_in) ^ ODD_BIT;
               cyc_d   = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end)
               state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = PARITY;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end)
               state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The line is registered, so it is driven from the next-state view.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cyc_q      <= '0;
         bit_q      <= '0;
         par_q      <= 1'b0;
         tx_out     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cyc_q      <= cyc_d;
         bit_q      <= bit_d;
         par_q      <= par_d;
         tx_out     <= tx_d;
         frame_done <= done_d;
      end
   end

`ifdef PARITY_TX_FRAME_CNT_EN
   // Counts in step with frame_done, so an aborted frame never counts.
   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= '0;
      else if (done_d)
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: default, odd-parity, slow-bit and 1-bit-wide instances.
// Frame counter checks run when PARITY_TX_FRAME_CNT_EN is defined.
module tb_parity_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din1;
   logic       vin;
   logic [3:0] rdy_o, tx_o, busy_o, done_o;
`ifdef PARITY_TX_FRAME_CNT_EN
   logic [31:0] cnt_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] cap_tx [4];
   logic [63:0] cap_busy [4];
   logic [63:0] cap_done [4];
   logic [63:0] cap_rdy [4];

   always #5 clk = ~clk;

   parity_tx #(.DATA_W(8), .BIT_CYCLES(1), .ODD_PARITY(0)) u_even (
      .clk(clk), .reset(rst), .data_in(din), .valid_in(vin), .ready_out(rdy_o[0]),
      .tx_out(tx_o[0]), .busy(busy_o[0]), .frame_done(done_o[0])
`ifdef PARITY_TX_FRAME_CNT_EN
      , .frame_cnt(cnt_o[7:0])
`endif
   );

   parity_tx #(.DATA_W(8), .BIT_CYCLES(1), .ODD_PARITY(1)) u_odd (
      .clk(clk), .reset(rst), .data_in(din), .valid_in(vin), .ready_out(rdy_o[1]),
      .tx_out(tx_o[1]), .busy(busy_o[1]), .frame_done(done_o[1])
`ifdef PARITY_TX_FRAME_CNT_EN
      , .frame_cnt(cnt_o[15:8])
`endif
   );

   parity_tx #(.DATA_W(8), .BIT_CYCLES(4), .ODD_PARITY(0)) u_slow (
      .clk(clk), .reset(rst), .data_in(din), .valid_in(vin), .ready_out(rdy_o[2]),
      .tx_out(tx_o[2]), .busy(busy_o[2]), .frame_done(done_o[2])
`ifdef PARITY_TX_FRAME_CNT_EN
      , .frame_cnt(cnt_o[23:16])
`endif
   );

   parity_tx #(.DATA_W(1), .BIT_CYCLES(1), .ODD_PARITY(0)) u_w1 (
      .clk(clk), .reset(rst), .data_in(din1), .valid_in(vin), .ready_out(rdy_o[3]),
      .tx_out(tx_o[3]), .busy(busy_o[3]), .frame_done(done_o[3])
`ifdef PARITY_TX_FRAME_CNT_EN
      , .frame_cnt(cnt_o[31:24])
`endif
   );

   // Record n samples of every instance, one per falling edge, starting at index base.
   task automatic capture(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) begin
            cap_tx[j][base+i]   = tx_o[j];
            cap_busy[j][base+i] = busy_o[j];
            cap_done[j][base+i] = done_o[j];
            cap_rdy[j][base+i]  = rdy_o[j];
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      vin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one word for a single accept edge; returns just after that edge.
   task automatic start_word(input logic [7:0] d, input logic d1);
      din  = d;
      din1 = d1;
      vin  = 1'b1;
      @(posedge clk);
      #1 vin = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      vin = 1'b1;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         vectors++;
         if (tx_o[j] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx inst %0d got %b want 1", j, tx_o[j]);
         end
         vectors++;
         if (busy_o[j] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy inst %0d got %b want 0", j, busy_o[j]);
         end
         vectors++;
         if (done_o[j] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done inst %0d got %b want 0", j, done_o[j]);
         end
         vectors++;
         if (rdy_o[j] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready inst %0d got %b want 1", j, rdy_o[j]);
         end
      end
      vin = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_even_frame();
      do_reset();
      start_word(8'hA5, 1'b0);
      capture(0, 12);
      vectors++;
      if (cap_tx[0][11:0] !== 12'hD4A) begin
         miscompares++;
         $display("FAIL even_tx got %h want %h", cap_tx[0][11:0], 12'hD4A);
      end
      vectors++;
      if (cap_busy[0][11:0] !== 12'h7FF) begin
         miscompares++;
         $display("FAIL even_busy got %h want %h", cap_busy[0][11:0], 12'h7FF);
      end
      vectors++;
      if (cap_done[0][11:0] !== 12'h800) begin
         miscompares++;
         $display("FAIL even_done got %h want %h", cap_done[0][11:0], 12'h800);
      end
      vectors++;
      if (cap_rdy[0][11:0] !== 12'h800) begin
         miscompares++;
         $display("FAIL even_ready got %h want %h", cap_rdy[0][11:0], 12'h800);
      end
   endtask

   task automatic test_parity();
      logic [7:0] words [3]    = '{8'h00, 8'h07, 8'hFF};
      logic       even_par [3] = '{1'b0, 1'b1, 1'b0};
      logic       odd_par [3]  = '{1'b1, 1'b0, 1'b1};
      logic [11:0] exp_e, exp_o;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         start_word(words[k], 1'b0);
         capture(0, 12);
         exp_e = {2'b11, even_par[k], words[k], 1'b0};
         exp_o = {2'b11, odd_par[k], words[k], 1'b0};
         vectors++;
         if (cap_tx[0][11:0] !== exp_e) begin
            miscompares++;
            $display("FAIL parity_even word %h got %h want %h", words[k], cap_tx[0][11:0], exp_e);
         end
         vectors++;
         if (cap_tx[1][11:0] !== exp_o) begin
            miscompares++;
            $display("FAIL parity_odd word %h got %h want %h", words[k], cap_tx[1][11:0], exp_o);
         end
      end
   endtask

   task automatic test_slow_bits();
      logic [10:0] fb = 11'b10001111000;
      int bad = 0;
      do_reset();
      start_word(8'h3C, 1'b0);
      capture(0, 45);
      for (int k = 0; k < 44; k++)
         if (cap_tx[2][k] !== fb[k/4]) bad++;
      if (cap_tx[2][44] !== 1'b1) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL slow_tx got %0d wrong samples want 0 (line %h)", bad, cap_tx[2][44:0]);
      end
      vectors++;
      if (cap_busy[2][44:0] !== {1'b0, {44{1'b1}}}) begin
         miscompares++;
         $display("FAIL slow_busy got %h want 44 busy cycles", cap_busy[2][44:0]);
      end
      vectors++;
      if (cap_done[2][44:0] !== {1'b1, 44'h0}) begin
         miscompares++;
         $display("FAIL slow_done got %h want single pulse at sample 44", cap_done[2][44:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp_tx = {1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0};
      do_reset();
      din = 8'h12;
      vin = 1'b1;
      @(posedge clk);
      capture(0, 1);
      din = 8'h34;
      capture(1, 11);
      capture(12, 1);
      vin = 1'b0;
      capture(13, 11);
      vectors++;
      if (cap_tx[0][23:0] !== exp_tx) begin
         miscompares++;
         $display("FAIL b2b_tx got %h want %h", cap_tx[0][23:0], exp_tx);
      end
      vectors++;
      if (cap_done[0][23:0] !== 24'h800800) begin
         miscompares++;
         $display("FAIL b2b_done got %h want %h", cap_done[0][23:0], 24'h800800);
      end
      vectors++;
      if (cap_busy[0][23:0] !== 24'h7FF7FF) begin
         miscompares++;
         $display("FAIL b2b_busy got %h want %h", cap_busy[0][23:0], 24'h7FF7FF);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      start_word(8'hFF, 1'b0);
      capture(0, 5);
      rst = 1'b1;
      capture(5, 1);
      rst = 1'b0;
      capture(6, 2);
      vectors++;
      if (cap_tx[0][5:0] !== 6'b111110) begin
         miscompares++;
         $display("FAIL abort_tx got %b want %b", cap_tx[0][5:0], 6'b111110);
      end
      vectors++;
      if (cap_busy[0][7:5] !== 3'b000 || cap_rdy[0][5] !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_idle got busy %b ready %b want busy 000 ready 1", cap_busy[0][7:5], cap_rdy[0][5]);
      end
      vectors++;
      if (cap_done[0][7:0] !== 8'h00) begin
         miscompares++;
         $display("FAIL abort_done got %h want 00", cap_done[0][7:0]);
      end
      start_word(8'h5A, 1'b0);
      capture(0, 12);
      vectors++;
      if (cap_tx[0][11:0] !== {2'b11, 1'b0, 8'h5A, 1'b0}) begin
         miscompares++;
         $display("FAIL after_abort_tx got %h want %h", cap_tx[0][11:0], {2'b11, 1'b0, 8'h5A, 1'b0});
      end
      // Reset and accept on the same edge: nothing may start.
      rst = 1'b1;
      din = 8'h81;
      vin = 1'b1;
      capture(0, 1);
      rst = 1'b0;
      vin = 1'b0;
      capture(1, 2);
      vectors++;
      if (cap_busy[0][2:0] !== 3'b000 || cap_tx[0][2:0] !== 3'b111) begin
         miscompares++;
         $display("FAIL reset_accept got busy %b tx %b want 000 111", cap_busy[0][2:0], cap_tx[0][2:0]);
      end
      // Reset on the edge that would end STOP: no frame_done.
      start_word(8'hA5, 1'b0);
      capture(0, 11);
      rst = 1'b1;
      capture(11, 1);
      rst = 1'b0;
      vectors++;
      if (cap_done[0][11] !== 1'b0 || cap_tx[0][11] !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_abort got done %b tx %b want 0 1", cap_done[0][11], cap_tx[0][11]);
      end
`ifdef PARITY_TX_FRAME_CNT_EN
      vectors++;
      if (cnt_o[7:0] !== 8'd0) begin
         miscompares++;
         $display("FAIL abort_cnt got %0d want 0", cnt_o[7:0]);
      end
`endif
   endtask

   task automatic test_width1();
      do_reset();
      start_word(8'h00, 1'b1);
      capture(0, 5);
      vectors++;
      if (cap_tx[3][4:0] !== 5'b11110 || cap_done[3][4:0] !== 5'b10000) begin
         miscompares++;
         $display("FAIL w1_one got tx %b done %b want 11110 10000", cap_tx[3][4:0], cap_done[3][4:0]);
      end
      start_word(8'h00, 1'b0);
      capture(0, 5);
      vectors++;
      if (cap_tx[3][4:0] !== 5'b11000 || cap_done[3][4:0] !== 5'b10000) begin
         miscompares++;
         $display("FAIL w1_zero got tx %b done %b want 11000 10000", cap_tx[3][4:0], cap_done[3][4:0]);
      end
   endtask

`ifdef PARITY_TX_FRAME_CNT_EN
   task automatic test_frame_cnt();
      do_reset();
      @(negedge clk);
      vectors++;
      if (cnt_o[7:0] !== 8'd0) begin
         miscompares++;
         $display("FAIL cnt_reset got %0d want 0", cnt_o[7:0]);
      end
      for (int f = 0; f < 257; f++) begin
         start_word(8'h3C, 1'b0);
         repeat (12) @(negedge clk);
      end
      vectors++;
      if (cnt_o[7:0] !== 8'd1) begin
         miscompares++;
         $display("FAIL cnt_wrap got %0d want 1", cnt_o[7:0]);
      end
   endtask
`endif

   initial begin
      rst  = 1'b1;
      vin  = 1'b0;
      din  = 8'h00;
      din1 = 1'b0;
      test_reset();
      test_even_frame();
      test_parity();
      test_slow_bits();
      test_back_to_back();
      test_reset_mid_frame();
      test_width1();
`ifdef PARITY_TX_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
